// File: rtl/uart_cmd_parser_pkg.sv
// Shared types and constants for the UART command parser.
//  - parser_state_e : parser FSM states
//  - OP_MMULT       : opcode byte that starts a MATRIX_MULT packet
//  - MAX_DIM        : largest legal matrix dimension (1..MAX_DIM)
//  - ADDR_W         : operand buffer address width (MAX_DIM*MAX_DIM elements)
//  - MATRIX_A/H     : operand buffer select values
//  - dim_ok()       : legal-dimension test used when the header completes
package uart_cmd_parser_pkg;

    localparam logic [7:0] OP_MMULT = 8'h01;
    localparam int         MAX_DIM  = 8;
    localparam int         ADDR_W   = 6;
    localparam logic       MATRIX_A = 1'b0;
    localparam logic       MATRIX_H = 1'b1;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_DIM    = 3'd1,
        S_LOAD_A = 3'd2,
        S_LOAD_H = 3'd3,
        S_DONE   = 3'd4,
        S_ERR    = 3'd5
    } parser_state_e;

    function automatic logic dim_ok(input logic [7:0] d);
        return (d != 8'd0) && (d <= 8'(MAX_DIM));
    endfunction

endpackage

// File: rtl/uart_cmd_parser_fp_word_assembler.sv
// Packs four received bytes (MSB first) into one 32-bit FP word.
// Ports:
//  clk, rst    clock, synchronous active-high reset
//  clr         synchronous clear of any partial word (parser outside LOAD_*)
//  byte_valid  one-cycle strobe: byte_data belongs to the current word
//  byte_data   received byte
//  word        assembled word (valid while word_valid is high)
//  word_valid  one-cycle pulse the cycle after the 4th byte
module uart_cmd_parser_fp_word_assembler (
    input  logic        clk,
    input  logic        rst,
    input  logic        clr,
    input  logic        byte_valid,
    input  logic [7:0]  byte_data,
    output logic [31:0] word,
    output logic        word_valid
);

    logic [31:0] shift_r;
    logic [1:0]  byte_cnt_r;
    logic        valid_r;

    // Byte shift register, byte counter and completion pulse.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            shift_r    <= 32'd0;
            byte_cnt_r <= 2'd0;
            valid_r    <= 1'b0;
        end else begin
            valid_r <= 1'b0;
            if (byte_valid) begin
                shift_r    <= {shift_r[23:0], byte_data};
                byte_cnt_r <= byte_cnt_r + 2'd1;
                if (byte_cnt_r == 2'd3) begin
                    valid_r <= 1'b1;
                end
            end
        end
    end

    assign word       = shift_r;
    assign word_valid = valid_r;

endmodule

// File: rtl/uart_cmd_parser.sv
// Byte-level MATRIX_MULT command decoder.
// Packet: opcode, a_h, a_w, h_h, h_w, then a_h*a_w A words and h_h*h_w H
// words, each 4 bytes MSB first, row-major.
// Ports:
//  clk, rst              clock, synchronous active-high reset
//  rx_done, rx_data      one-cycle received-byte strobe and byte
//  eng_busy              engine busy; opcodes rejected while high (IDLE only)
//  wr_en/wr_sel/wr_addr/wr_data  operand buffer write port
//  a_h, a_w, h_h, h_w    latched dimensions
//  cmd_start             one-cycle pulse when both matrices are loaded
//  pkt_err               one-cycle pulse on rejected/abandoned packet
//  parser_busy           high whenever the parser is not IDLE
module uart_cmd_parser
    import uart_cmd_parser_pkg::*;
#(
    parameter int TIMEOUT_CYC = 500000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rx_done,
    input  logic [7:0]        rx_data,
    input  logic              eng_busy,
    output logic              wr_en,
    output logic              wr_sel,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [31:0]       wr_data,
    output logic [7:0]        a_h,
    output logic [7:0]        a_w,
    output logic [7:0]        h_h,
    output logic [7:0]        h_w,
    output logic              cmd_start,
    output logic              pkt_err,
    output logic              parser_busy
);

    localparam int TO_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;

    parser_state_e state_r;
    logic [1:0]    dim_idx_r;
    logic [12:0]   elem_cnt_r;
    logic [12:0]   prod_a_r;
    logic [12:0]   prod_h_r;
    logic [TO_W-1:0] gap_cnt_r;
    logic [7:0]    a_h_r, a_w_r, h_h_r, h_w_r;
    logic          wr_sel_r;
    logic          cmd_start_r;
    logic          pkt_err_r;
    logic          busy_r;

    logic          load_s;
    logic          counting_s;
    logic          timeout_s;
    logic          dims_ok_s;
    logic          word_valid_s;
    logic [31:0]   word_s;

    // State decodes, timeout detect and header legality (rx_data is h_w here).
    always_comb begin
        load_s     = (state_r == S_LOAD_A) || (state_r == S_LOAD_H);
        counting_s = load_s || (state_r == S_DIM);
        timeout_s  = counting_s && !rx_done &&
                     (gap_cnt_r == TO_W'(TIMEOUT_CYC - 1));
        dims_ok_s  = dim_ok(a_h_r) && dim_ok(a_w_r) && dim_ok(h_h_r) &&
                     dim_ok(rx_data) && (a_w_r == h_h_r);
    end

    // Only LOAD_* bytes reach the assembler; leaving LOAD_* drops partial words.
    uart_cmd_parser_fp_word_assembler u_asm (
        .clk        (clk),
        .rst        (rst),
        .clr        (!load_s),
        .byte_valid (rx_done && load_s),
        .byte_data  (rx_data),
        .word       (word_s),
        .word_valid (word_valid_s)
    );

    // Parser FSM with dimension, element and inter-byte gap counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= S_IDLE;
            dim_idx_r   <= 2'd0;
            elem_cnt_r  <= 13'd0;
            prod_a_r    <= 13'd0;
            prod_h_r    <= 13'd0;
            gap_cnt_r   <= TO_W'(0);
            a_h_r       <= 8'd0;
            a_w_r       <= 8'd0;
            h_h_r       <= 8'd0;
            h_w_r       <= 8'd0;
            wr_sel_r    <= MATRIX_A;
            cmd_start_r <= 1'b0;
            pkt_err_r   <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            cmd_start_r <= 1'b0;
            pkt_err_r   <= 1'b0;

            if (rx_done || !counting_s) begin
                gap_cnt_r <= TO_W'(0);
            end else begin
                gap_cnt_r <= gap_cnt_r + TO_W'(1);
            end

            case (state_r)
                S_IDLE: begin
                    if (rx_done) begin
                        if ((rx_data == OP_MMULT) && !eng_busy) begin
                            state_r   <= S_DIM;
                            busy_r    <= 1'b1;
                            dim_idx_r <= 2'd0;
                        end else begin
                            pkt_err_r <= 1'b1;
                        end
                    end
                end
                S_DIM: begin
                    if (rx_done) begin
                        dim_idx_r <= dim_idx_r + 2'd1;
                        case (dim_idx_r)
                            2'd0:    a_h_r <= rx_data;
                            2'd1:    a_w_r <= rx_data;
                            2'd2:    h_h_r <= rx_data;
                            default: begin
                                h_w_r <= rx_data;
                                if (dims_ok_s) begin
                                    state_r    <= S_LOAD_A;
                                    prod_a_r   <= {5'd0, a_h_r} * {5'd0, a_w_r};
                                    prod_h_r   <= {5'd0, h_h_r} * {5'd0, rx_data};
                                    elem_cnt_r <= 13'd0;
                                    wr_sel_r   <= MATRIX_A;
                                end else begin
                                    state_r   <= S_ERR;
                                    pkt_err_r <= 1'b1;
                                end
                            end
                        endcase
                    end else if (timeout_s) begin
                        state_r   <= S_ERR;
                        pkt_err_r <= 1'b1;
                    end
                end
                S_LOAD_A: begin
                    // The write goes out this cycle at elem_cnt_r; advance after it.
                    if (word_valid_s) begin
                        if ((elem_cnt_r + 13'd1) == prod_a_r) begin
                            state_r    <= S_LOAD_H;
                            elem_cnt_r <= 13'd0;
                            wr_sel_r   <= MATRIX_H;
                        end else begin
                            elem_cnt_r <= elem_cnt_r + 13'd1;
                        end
                    end else if (timeout_s) begin
                        state_r   <= S_ERR;
                        pkt_err_r <= 1'b1;
                    end
                end
                S_LOAD_H: begin
                    if (word_valid_s) begin
                        if ((elem_cnt_r + 13'd1) == prod_h_r) begin
                            state_r     <= S_DONE;
                            cmd_start_r <= 1'b1;
                            elem_cnt_r  <= 13'd0;
                            wr_sel_r    <= MATRIX_A;
                        end else begin
                            elem_cnt_r <= elem_cnt_r + 13'd1;
                        end
                    end else if (timeout_s) begin
                        state_r   <= S_ERR;
                        pkt_err_r <= 1'b1;
                    end
                end
                S_DONE: begin
                    state_r <= S_IDLE;
                    busy_r  <= 1'b0;
                end
                S_ERR: begin
                    state_r    <= S_IDLE;
                    busy_r     <= 1'b0;
                    elem_cnt_r <= 13'd0;
                    dim_idx_r  <= 2'd0;
                    wr_sel_r   <= MATRIX_A;
                end
                default: begin
                    state_r <= S_IDLE;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

    assign wr_en       = word_valid_s;
    assign wr_data     = word_s;
    assign wr_sel      = wr_sel_r;
    assign wr_addr     = elem_cnt_r[ADDR_W-1:0];
    assign a_h         = a_h_r;
    assign a_w         = a_w_r;
    assign h_h         = h_h_r;
    assign h_w         = h_w_r;
    assign cmd_start   = cmd_start_r;
    assign pkt_err     = pkt_err_r;
    assign parser_busy = busy_r;

endmodule
